spi_cfg_bank: RTL and testbench
===============================

# spi_cfg_bank

Parametrised SPI configuration slave for the SNN chip. It combines bit shifting, the command/address protocol FSM and a byte-addressed configuration register bank in one clock domain driven by `SCLK`. Over a 16-bit addressed protocol it supports multi-byte burst writes and burst read-back with address auto-increment. It exposes the whole bank as a flat vector to the neuron core and flags protocol errors.

## Interface
Parameters:
- `NUM_BYTES`, 125: number of configuration bytes in the bank; valid addresses are 0 to NUM_BYTES-1.
- `ADDR_W`, 16: protocol address width. Sent as two bytes, MSB first. Fixed at 16 in this generation.

Ports:
- `SCLK`, in, 1: SPI clock and the only clock. All logic uses its rising edge.
- `RESET`, in, 1: synchronous, active-high reset.
- `SS`, in, 1: chip select, active low, sampled on `SCLK`.
- `MOSI`, in, 1: serial data in, MSB first.
- `MISO`, out, 1: serial data out, MSB first, registered.
- `all_data_out`, out, NUM_BYTES*8: flat bank; byte k sits at bits [8k+7:8k].
- `data_valid_out`, out, 1: one-cycle pulse per fully received byte, in any phase.
- `cfg_write_strobe`, out, 1: one-cycle pulse per committed bank write.
- `cfg_write_addr`, out, ADDR_W: address of the last committed write.
- `spi_instruction_done`, out, 1: one-cycle pulse at frame end after a completed address phase.
- `err_flag`, out, 1: sticky protocol error.

## Operation
- Opcodes (first byte of a frame):
  - 0x01 WRITE
  - 0x02 READ
  - 0x03 CLR_ERR
  - Any other value is invalid.
- WRITE frame: opcode, ADDR_H, ADDR_L, then data bytes D0..Dn. Each Di is written to address A+i.
- READ frame: opcode, ADDR_H, ADDR_L, one dummy byte (MOSI ignored), then mem[A], mem[A+1], … are shifted out on `MISO`.
- CLR_ERR frame: clears `err_flag` when the opcode byte completes. Any further bytes in the frame are ignored.
- FSM states:
  - CMD → ADDR_H → ADDR_L.
  - From ADDR_L: → WDATA (WRITE) or → DUMMY → RDATA (READ).
  - CMD → IGNORE for CLR_ERR or an invalid opcode.
  - Any state → CMD on a rising edge with `SS` high. This also clears the bit counter.
- A 3-bit bit counter advances only while `SS` is low. A byte completes on the edge that samples its 8th bit.
- The address counter loads at ADDR_L completion and increments after each data byte, in both WDATA and RDATA. It wraps modulo 2^16.
- Out-of-range address (≥ NUM_BYTES):
  - Write: dropped, no strobe, `err_flag` set.
  - Read: returns 0x00 and sets `err_flag`.
- An invalid opcode sets `err_flag`. `MISO` stays 0 for the rest of that frame.
- Frame abort (`SS` high before a byte completes): the partial byte is discarded and bytes already committed remain.
- Simultaneous events: CLR_ERR completion and an error cannot coincide within one frame. Across frames, set wins over clear on the same edge.

## Timing
- Reset values:
  - Bank all 0x00, so `all_data_out` = 0.
  - `MISO` = 0; `data_valid_out`, `cfg_write_strobe`, `spi_instruction_done` = 0.
  - `cfg_write_addr` = 0, `err_flag` = 0, FSM in CMD.
- `RESET` mid-frame returns to CMD on that edge. It also clears the bank; no partial commit occurs.
- Write latency: a byte completing on edge N is visible on `all_data_out` and `cfg_write_addr` after edge N. `cfg_write_strobe` and `data_valid_out` are high for the cycle between edges N and N+1.
- Read: on the edge completing the dummy byte, `MISO` takes bit 7 of mem[A]. Each following edge shifts out the next bit. On the 8th bit edge, bit 7 of the next byte is loaded, with no gap. The host samples `MISO` on the falling edge.
- `spi_instruction_done`: pulses for one cycle on the first `SS`-high edge after a frame that reached WDATA, DUMMY or RDATA.
- Frame separation: the host must supply at least one `SCLK` rising edge with `SS` high between frames.

## Configuration
- `SPI_CFG_READBACK_EN`:
  - Defined: READ (0x02) behaves as described above.
  - Undefined: 0x02 is an invalid opcode, so `err_flag` is set, `MISO` holds 0, and the DUMMY/RDATA states and read mux are not built.

## Test plan
- Reset, then WRITE A=0x0003 with data 0x5A → byte 3 = 0x5A, `cfg_write_addr`=3, exactly one strobe, `err_flag`=0.
- WRITE burst A=0x0004 with 0x11,0x22,0x33 → bytes 4..6 = 0x11,0x22,0x33; three strobes; `spi_instruction_done` pulses once after `SS` rises.
- READ A=0x0004 with 3 bytes clocked (READBACK_EN defined) → `MISO` returns 0x11,0x22,0x33 MSB-first, starting right after the dummy byte.
- WRITE A=NUM_BYTES-1 with 0xAA,0xBB → last byte = 0xAA, 0xBB dropped, one strobe, `err_flag`=1. A following CLR_ERR frame → `err_flag`=0.
- Opcode 0x7F followed by 3 bytes → bank unchanged, `MISO`=0 throughout, `err_flag`=1. With READBACK_EN undefined, opcode 0x02 gives the same response.
- `SS` raised after 4 bits of a WRITE data byte, then `RESET` asserted mid-frame → partial byte not written; after reset, all outputs at their reset values.

Source files
------------

// File: rtl/spi_cfg_bank.sv
// spi_cfg_bank: SPI configuration slave with shifter, command FSM and byte-addressed bank.
// Define SPI_CFG_READBACK_EN to build READ (0x02); otherwise 0x02 is treated as an invalid opcode.
module spi_cfg_bank #(
    parameter int unsigned NUM_BYTES = 125,
    parameter int unsigned ADDR_W    = 16
) (
    input  logic                   SCLK,
    input  logic                   RESET,
    input  logic                   SS,
    input  logic                   MOSI,
    output logic                   MISO,
    output logic [NUM_BYTES*8-1:0] all_data_out,
    output logic                   data_valid_out,
    output logic                   cfg_write_strobe,
    output logic [ADDR_W-1:0]      cfg_write_addr,
    output logic                   spi_instruction_done,
    output logic                   err_flag
);

    localparam int unsigned       IdxW      = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [ADDR_W-1:0] NumBytesA = ADDR_W'(NUM_BYTES);
    localparam logic [7:0]        OpWrite   = 8'h01;
    localparam logic [7:0]        OpClrErr  = 8'h03;
`ifdef SPI_CFG_READBACK_EN
    localparam logic [7:0]        OpRead    = 8'h02;
`endif

    typedef enum logic [2:0] {
        StCmd,
        StAddrH,
        StAddrL,
        StWdata,
        StDummy,
        StRdata,
        StIgnore
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        shift_q, shift_d;
    logic [7:0]        addr_h_q, addr_h_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              err_q, err_d;
    logic              valid_q, valid_d;
    logic              strobe_q, strobe_d;
    logic              done_q, done_d;
    logic [7:0]        mem_q [NUM_BYTES];

    logic [7:0]        rx_byte;
    logic              byte_done;
    logic              addr_in_range;
    logic              mem_we;
    logic              err_set;
    logic              err_clr;

`ifdef SPI_CFG_READBACK_EN
    logic              is_read_q, is_read_d;
    logic [6:0]        tx_q, tx_d;
    logic              miso_q, miso_d;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_in_range;
    logic [7:0]        rd_byte;

    // Byte to present next: current address after the dummy byte, look-ahead while streaming.
    always_comb begin
        rd_addr     = (state_q == StRdata) ? addr_q + ADDR_W'(1) : addr_q;
        rd_in_range = (rd_addr < NumBytesA);
        rd_byte     = rd_in_range ? mem_q[rd_addr[IdxW-1:0]] : 8'h00;
    end
`endif

    assign addr_in_range = (addr_q < NumBytesA);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        addr_h_d  = addr_h_q;
        addr_d    = addr_q;
        wr_addr_d = wr_addr_q;
        valid_d   = 1'b0;
        strobe_d  = 1'b0;
        done_d    = 1'b0;
        mem_we    = 1'b0;
        err_set   = 1'b0;
        err_clr   = 1'b0;
        rx_byte   = {shift_q, MOSI};
        byte_done = 1'b0;
`ifdef SPI_CFG_READBACK_EN
        is_read_d = is_read_q;
        tx_d      = tx_q;
        miso_d    = 1'b0;
`endif

        if (SS) begin
            state_d   = StCmd;
            bit_cnt_d = '0;
            shift_d   = '0;
            done_d    = (state_q == StWdata) || (state_q == StDummy) || (state_q == StRdata);
        end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = rx_byte[6:0];
            byte_done = (bit_cnt_q == 3'd7);
            valid_d   = byte_done;
`ifdef SPI_CFG_READBACK_EN
            if ((state_q == StRdata) && !byte_done) begin
                miso_d = tx_q[6];
                tx_d   = {tx_q[5:0], 1'b0};
            end
`endif
            if (byte_done) begin
                case (state_q)
                    StCmd: begin
                        if (rx_byte == OpWrite) begin
                            state_d = StAddrH;
`ifdef SPI_CFG_READBACK_EN
                        end else if (rx_byte == OpRead) begin
                            state_d = StAddrH;
`endif
                        end else begin
                            state_d = StIgnore;
                            if (rx_byte == OpClrErr) begin
                                err_clr = 1'b1;
                            end else begin
                                err_set = 1'b1;
                            end
                        end
`ifdef SPI_CFG_READBACK_EN
                        is_read_d = (rx_byte == OpRead);
`endif
                    end
                    StAddrH: begin
                        addr_h_d = rx_byte;
                        state_d  = StAddrL;
                    end
                    StAddrL: begin
                        addr_d = ADDR_W'({addr_h_q, rx_byte});
`ifdef SPI_CFG_READBACK_EN
                        state_d = is_read_q ? StDummy : StWdata;
`else
                        state_d = StWdata;
`endif
                    end
                    StWdata: begin
                        if (addr_in_range) begin
                            mem_we    = 1'b1;
                            strobe_d  = 1'b1;
                            wr_addr_d = addr_q;
                        end else begin
                            err_set = 1'b1;
                        end
                        addr_d = addr_q + ADDR_W'(1);
                    end
`ifdef SPI_CFG_READBACK_EN
                    StDummy, StRdata: begin
                        if (state_q == StRdata) begin
                            addr_d = addr_q + ADDR_W'(1);
                        end
                        state_d = StRdata;
                        miso_d  = rd_byte[7];
                        tx_d    = rd_byte[6:0];
                        if (!rd_in_range) begin
                            err_set = 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    // Set has priority so an error on the same edge is never lost.
    assign err_d = (err_q & ~err_clr) | err_set;

    always_ff @(posedge SCLK) begin
        if (RESET) begin
            state_q   <= StCmd;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            addr_h_q  <= '0;
            addr_q    <= '0;
            wr_addr_q <= '0;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
            strobe_q  <= 1'b0;
            done_q    <= 1'b0;
            for (int unsigned k = 0; k < NUM_BYTES; k++) begin
                mem_q[k] <= 8'h00;
            end
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            addr_h_q  <= addr_h_d;
            addr_q    <= addr_d;
            wr_addr_q <= wr_addr_d;
            err_q     <= err_d;
            valid_q   <= valid_d;
            strobe_q  <= strobe_d;
            done_q    <= done_d;
            if (mem_we) begin
                mem_q[addr_q[IdxW-1:0]] <= rx_byte;
            end
        end
    end

`ifdef SPI_CFG_READBACK_EN
    always_ff @(posedge SCLK) begin
        if (RESET) begin
            is_read_q <= 1'b0;
            tx_q      <= '0;
            miso_q    <= 1'b0;
        end else begin
            is_read_q <= is_read_d;
            tx_q      <= tx_d;
            miso_q    <= miso_d;
        end
    end

    assign MISO = miso_q;
`else
    assign MISO = 1'b0;
`endif

    for (genvar k = 0; k < NUM_BYTES; k++) begin : g_flat
        assign all_data_out[8*k +: 8] = mem_q[k];
    end

    assign data_valid_out       = valid_q;
    assign cfg_write_strobe     = strobe_q;
    assign cfg_write_addr       = wr_addr_q;
    assign spi_instruction_done = done_q;
    assign err_flag             = err_q;

endmodule

// File: tb/tb_spi_cfg_bank.sv
// Bench for spi_cfg_bank: directed frames plus randomized frames checked against a
// frame-level model of the bank, error flag, pulse counts and read-back stream.
module tb_spi_cfg_bank;

    localparam int unsigned N  = 125;
    localparam int unsigned AW = 16;
`ifdef SPI_CFG_READBACK_EN
    localparam bit RbEn = 1'b1;
`else
    localparam bit RbEn = 1'b0;
`endif

    logic           SCLK;
    logic           RESET;
    logic           SS;
    logic           MOSI;
    logic           MISO;
    logic [N*8-1:0] all_data_out;
    logic           data_valid_out;
    logic           cfg_write_strobe;
    logic [AW-1:0]  cfg_write_addr;
    logic           spi_instruction_done;
    logic           err_flag;

    spi_cfg_bank #(
        .NUM_BYTES(N),
        .ADDR_W   (AW)
    ) dut (
        .SCLK                (SCLK),
        .RESET               (RESET),
        .SS                  (SS),
        .MOSI                (MOSI),
        .MISO                (MISO),
        .all_data_out        (all_data_out),
        .data_valid_out      (data_valid_out),
        .cfg_write_strobe    (cfg_write_strobe),
        .cfg_write_addr      (cfg_write_addr),
        .spi_instruction_done(spi_instruction_done),
        .err_flag            (err_flag)
    );

    initial SCLK = 1'b0;
    always #5 SCLK = ~SCLK;

    int          n_pass;
    int          n_total;
    int          cnt_valid;
    int          cnt_strobe;
    int          cnt_done;
    logic        miso_log[$];
    logic [7:0]  fr[$];

    logic [7:0]  m_mem [N];
    logic        m_err;
    int unsigned m_wr_addr;
    int          m_strobes;
    int          m_done;
    bit          m_is_read;
    logic [7:0]  m_rd[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic chk_bank(input string tag);
        logic [N*8-1:0] expv;
        int             first;
        for (int k = 0; k < int'(N); k++) expv[8*k +: 8] = m_mem[k];
        first = 0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            if (all_data_out[8*k +: 8] !== expv[8*k +: 8]) first = k;
        end
        n_total++;
        assert (all_data_out === expv) n_pass++;
        else $error("FAIL %s: byte %0d got 0x%02h expected 0x%02h", tag, first,
                    all_data_out[8*first +: 8], expv[8*first +: 8]);
    endtask

    // One SCLK rising edge with the given inputs; outputs observed on the following falling edge.
    task automatic step(input logic rst, input logic ss, input logic mosi);
        RESET = rst;
        SS    = ss;
        MOSI  = mosi;
        @(posedge SCLK);
        @(negedge SCLK);
        cnt_valid  += int'(data_valid_out);
        cnt_strobe += int'(cfg_write_strobe);
        cnt_done   += int'(spi_instruction_done);
        if (!ss) miso_log.push_back(MISO);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) step(1'b0, 1'b0, b[7-i]);
    endtask

    task automatic push3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        fr.push_back(b0);
        fr.push_back(b1);
        fr.push_back(b2);
    endtask

    task automatic m_reset();
        for (int k = 0; k < int'(N); k++) m_mem[k] = 8'h00;
        m_err     = 1'b0;
        m_wr_addr = 0;
    endtask

    // Frame-level reference: walks the completed bytes of fr in protocol order.
    task automatic model_frame();
        int          nb;
        logic [7:0]  op;
        int unsigned a0;
        int unsigned a;
        nb        = fr.size();
        m_strobes = 0;
        m_done    = 0;
        m_is_read = 1'b0;
        m_rd.delete();
        if (nb > 0) begin
            op = fr[0];
            if (op == 8'h01 || (op == 8'h02 && RbEn)) begin
                if (nb >= 3) begin
                    m_done = 1;
                    a0     = 32'({fr[1], fr[2]});
                    if (op == 8'h01) begin
                        for (int i = 3; i < nb; i++) begin
                            a = (a0 + 32'(i) - 3) & 32'hFFFF;
                            if (a < N) begin
                                m_mem[a]  = fr[i];
                                m_strobes++;
                                m_wr_addr = a;
                            end else begin
                                m_err = 1'b1;
                            end
                        end
                    end else begin
                        m_is_read = 1'b1;
                        // After the dummy byte one byte is fetched per data byte, plus one ahead.
                        for (int j = 0; j <= nb - 4; j++) begin
                            a = (a0 + 32'(j)) & 32'hFFFF;
                            if (a < N) begin
                                m_rd.push_back(m_mem[a]);
                            end else begin
                                m_rd.push_back(8'h00);
                                m_err = 1'b1;
                            end
                        end
                    end
                end
            end else if (op == 8'h03) begin
                m_err = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic run_frame(input int abort_bits);
        cnt_valid  = 0;
        cnt_strobe = 0;
        cnt_done   = 0;
        miso_log.delete();
        foreach (fr[i]) send_bits(fr[i], 8);
        if (abort_bits > 0) send_bits(8'($urandom), abort_bits);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic check_frame(input string tag);
        logic [7:0] got;
        logic       any;
        chk_bank({tag, ".bank"});
        chk({tag, ".err"}, 32'(err_flag), 32'(m_err));
        chk({tag, ".strobes"}, cnt_strobe, m_strobes);
        chk({tag, ".done"}, cnt_done, m_done);
        chk({tag, ".valid"}, cnt_valid, fr.size());
        chk({tag, ".wr_addr"}, 32'(cfg_write_addr), m_wr_addr);
        any = 1'b0;
        if (m_is_read) begin
            for (int i = 0; i < 31 && i < miso_log.size(); i++) any |= miso_log[i];
            chk({tag, ".miso_pre"}, 32'(any), 0);
            for (int j = 0; j < m_rd.size() - 1; j++) begin
                got = 8'h00;
                for (int b = 0; b < 8; b++) got = {got[6:0], miso_log[31 + 8*j + b]};
                chk($sformatf("%s.rd%0d", tag, j), 32'(got), 32'(m_rd[j]));
            end
        end else begin
            foreach (miso_log[i]) any |= miso_log[i];
            chk({tag, ".miso0"}, 32'(any), 0);
        end
    endtask

    task automatic run_check(input string tag, input int abort_bits);
        run_frame(abort_bits);
        model_frame();
        check_frame(tag);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_bank({tag, ".bank"});
        chk({tag, ".miso"}, 32'(MISO), 0);
        chk({tag, ".valid"}, 32'(data_valid_out), 0);
        chk({tag, ".strobe"}, 32'(cfg_write_strobe), 0);
        chk({tag, ".done"}, 32'(spi_instruction_done), 0);
        chk({tag, ".wr_addr"}, 32'(cfg_write_addr), 0);
        chk({tag, ".err"}, 32'(err_flag), 0);
    endtask

    initial begin : main
        int          kind;
        int          nd;
        int          ab;
        int unsigned a;

        n_pass  = 0;
        n_total = 0;
        RESET   = 1'b1;
        SS      = 1'b1;
        MOSI    = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        m_reset();
        chk_reset_outputs("rst");
        step(1'b0, 1'b1, 1'b0);

        fr.delete(); push3(8'h01, 8'h00, 8'h03); fr.push_back(8'h5A);
        run_check("t1_write", 0);
        chk("t1_byte3", 32'(all_data_out[31:24]), 32'h5A);
        chk("t1_strobe1", cnt_strobe, 1);

        fr.delete(); push3(8'h01, 8'h00, 8'h04);
        fr.push_back(8'h11); fr.push_back(8'h22); fr.push_back(8'h33);
        run_check("t2_burst", 0);
        chk("t2_bytes", 32'(all_data_out[55:32]), 32'h332211);

        fr.delete(); push3(8'h02, 8'h00, 8'h04);
        fr.push_back(8'h00); fr.push_back(8'hA5); fr.push_back(8'h5A); fr.push_back(8'hFF);
        run_check("t3_read", 0);

        fr.delete(); fr.push_back(8'h03);
        run_check("t4_clr0", 0);
        fr.delete(); push3(8'h01, 8'((N - 1) >> 8), 8'(N - 1));
        fr.push_back(8'hAA); fr.push_back(8'hBB);
        run_check("t4_edge", 0);
        chk("t4_last", 32'(all_data_out[8*N-1 -: 8]), 32'hAA);
        chk("t4_err_set", 32'(err_flag), 1);
        fr.delete(); push3(8'h03, 8'h01, 8'h00); fr.push_back(8'h05); fr.push_back(8'h99);
        run_check("t4_clr", 0);
        chk("t4_err_clr", 32'(err_flag), 0);

        fr.delete(); push3(8'h7F, 8'h12, 8'h34); fr.push_back(8'h56);
        run_check("t5_bad", 0);
        chk("t5_err", 32'(err_flag), 1);
        fr.delete(); fr.push_back(8'h03);
        run_check("t5_clr", 0);

        fr.delete(); push3(8'h01, 8'hFF, 8'hFF); fr.push_back(8'h12); fr.push_back(8'h34);
        run_check("wrap", 0);

        for (int r = 0; r < 40; r++) begin
            kind = $urandom_range(0, 9);
            nd   = $urandom_range(0, 4);
            ab   = 0;
            fr.delete();
            if (kind <= 4) begin
                a = (kind == 4) ? N - 2 + $urandom_range(0, 3) : $urandom_range(0, N - 1);
                push3(8'h01, 8'(a >> 8), 8'(a));
                repeat (nd) fr.push_back(8'($urandom));
            end else if (kind <= 6) begin
                a = $urandom_range(0, N - 1);
                push3(8'h02, 8'(a >> 8), 8'(a));
                fr.push_back(8'($urandom));
                repeat (nd) fr.push_back(8'($urandom));
            end else if (kind == 7) begin
                fr.push_back(8'h03);
                repeat (nd % 3) fr.push_back(8'($urandom));
            end else if (kind == 8) begin
                fr.push_back(8'($urandom_range(4, 255)));
                repeat (nd) fr.push_back(8'($urandom));
            end else begin
                a = $urandom_range(0, N - 1);
                push3(8'h01, 8'(a >> 8), 8'(a));
                repeat (nd) fr.push_back(8'($urandom));
                ab = $urandom_range(1, 7);
            end
            run_check($sformatf("rnd%0d", r), ab);
        end

        fr.delete(); push3(8'h01, 8'h00, 8'h0A);
        run_check("abort", 4);

        fr.delete(); fr.push_back(8'h7F);
        run_check("pre_rst_err", 0);

        // Reset lands in the middle of a write data byte.
        fr.delete(); push3(8'h01, 8'h00, 8'h0B);
        foreach (fr[i]) send_bits(fr[i], 8);
        send_bits(8'hF0, 4);
        step(1'b1, 1'b0, 1'b1);
        m_reset();
        chk_reset_outputs("mrst");
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk_reset_outputs("mrst_idle");

        fr.delete(); push3(8'h01, 8'h00, 8'h00); fr.push_back(8'hC3);
        run_check("post_rst", 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
